mem_copy_engine: RTL and testbench
==================================

# mem_copy_engine

Sequencer that drives the ports of a small synchronous register-file memory (one write port, two registered read ports, one-cycle read latency). On command it either copies a block of words from a source region to a destination region, or compares two regions word-by-word and reports mismatches. It sits between a control/config agent and the memory, acting as the memory's sole port driver while busy.

## Interface
- AW, 2, address width; memory depth is 2^AW
- DW, 17, data width
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous reset, active low
- start  in  1  command strobe, sampled only when busy=0
- mode  in  1  0=copy, 1=compare; sampled with start
- src_base  in  AW  first source address
- dst_base  in  AW  first destination address
- len  in  AW+1  word count, 0..2^AW; values above 2^AW are clamped to 2^AW
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- mis_cnt  out  AW+1  compare mismatch count
- mis_valid  out  1  at least one mismatch seen
- mis_idx  out  AW  offset i of the first mismatch
- mem_raddr1  out  AW  read port 1 address
- mem_q1  in  DW  read port 1 data, registered in memory
- mem_raddr2  out  AW  read port 2 address
- mem_q2  in  DW  read port 2 data
- mem_waddr0  out  AW  write address
- mem_we0  out  1  write enable
- mem_din0  out  DW  write data

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset to IDLE from any state.
- IDLE/DONE with start=1 -> RUN if len>0, else DRAIN. The command fields, clamped length L, and mode are latched. mis_cnt, mis_valid, and mis_idx clear at the same edge.
- RUN: read counter i runs 0..L-1. Drive mem_raddr1=src_base+i. In compare mode, also drive mem_raddr2=dst_base+i. At i=L-1, go to DRAIN.
- DRAIN: no new read issued; the last write or compare completes. DRAIN -> DONE.
- DONE: done=1 for one cycle, then IDLE unless a new start is accepted.
- Copy: in the cycle after read i is issued, mem_we0=1, mem_waddr0=dst_base+i, mem_din0=mem_q1. mem_raddr2 is held at 0.
- Compare: in the cycle after read i is issued, mem_q1 is compared with mem_q2. A mismatch increments mis_cnt. On the first mismatch, set mis_valid=1 and mis_idx=i. mem_we0 stays 0 throughout.
- All address arithmetic is modulo 2^AW, so regions wrap past the top address.
- Overlap: no check is made. Each read samples memory state before any write committed at the same edge. Benches model this exactly.
- Idle outputs: mem_raddr1 = mem_raddr2 = mem_waddr0 = 0, mem_we0 = 0, mem_din0 = mem_q1 (don't care).
- start while busy=1 is ignored with no side effects.

## Timing
- Cycle k is the cycle after edge Ek; start is sampled at E0.
- busy=1 in cycles 0..L. done=1 only in cycle L+1. busy=0 from cycle L+1.
- Read i is driven in cycle i (i<L). Data is visible in cycle i+1.
- Write or compare i is driven in cycle i+1 and commits at E(i+2).
- mis_* are final in cycle L+1 and hold until the next accepted start.
- L=0: busy in cycle 0, done in cycle 1, no write and no compare.
- Back-to-back: start during the DONE cycle is accepted, and busy=1 in the next cycle.
- Reset (reset_n=0 at an edge): after that edge, state IDLE, busy=0, done=0, mem_we0=0, mis_cnt=0, mis_valid=0, mis_idx=0. Any write in flight is dropped, and a write driven in the same cycle as reset is still committed by the memory.
- Mode or command changes while busy are ignored.

## Test plan
- Copy, AW=2, memory preloaded [A,B,C,D], src=0, dst=2, len=2 -> mem_we0 high in cycles 1 and 2; memory becomes [A,B,A,B]; done in cycle 3.
- Wrap copy, memory [A,B,C,D], src=3, dst=1, len=2 -> writes addr1=D then addr2=A; memory becomes [A,D,A,D].
- Overlap copy, memory [A,B,C,D], src=0, dst=1, len=3 -> memory becomes [A,A,B,C].
- Compare, memory [5,5,7,9], src=0, dst=2, len=2 -> mis_cnt=2, mis_valid=1, mis_idx=0. A second run with src=0, dst=1, len=1 -> mis_cnt=0, mis_valid=0.
- len=0, and len=7 (clamped to 4): len=0 gives done in cycle 1 with no mem_we0. len=7 gives busy for cycles 0..4 and exactly 4 writes.
- Reset during cycle 2 of a len=4 copy -> busy=0, mem_we0=0 after the edge, no done pulse. start pulses during busy are ignored, and a start in the DONE cycle is accepted.

Source files
------------

// File: rtl/mem_copy_engine.sv
// mem_copy_engine
// Drives a small register-file memory (one write port, two registered read
// ports with one-cycle latency) to copy a block of words from a source region
// to a destination region, or to compare two regions and report mismatches.
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   start, mode             command strobe (taken only when idle); 0=copy, 1=compare
//   src_base, dst_base, len command fields; len is clamped to 2^AW
//   busy, done              command in progress; one-cycle completion pulse
//   mis_cnt, mis_valid,     compare results: mismatch count, any-mismatch flag,
//   mis_idx                 offset of the first mismatching word
//   mem_raddr1 / mem_q1     read port 1 (source words)
//   mem_raddr2 / mem_q2     read port 2 (destination words, compare only)
//   mem_waddr0, mem_we0,    write port (copy only)
//   mem_din0
module mem_copy_engine #(
  parameter int AW = 2,
  parameter int DW = 17
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src_base,
  input  logic [AW-1:0] dst_base,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   mis_cnt,
  output logic          mis_valid,
  output logic [AW-1:0] mis_idx,
  output logic [AW-1:0] mem_raddr1,
  input  logic [DW-1:0] mem_q1,
  output logic [AW-1:0] mem_raddr2,
  input  logic [DW-1:0] mem_q2,
  output logic [AW-1:0] mem_waddr0,
  output logic          mem_we0,
  output logic [DW-1:0] mem_din0
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [AW:0] LEN_MAX = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] LEN_ONE = (AW+1)'(1);

  // Word counts above the memory depth are treated as a full-memory pass.
  function automatic logic [AW:0] clamp_len(input logic [AW:0] l);
    logic [AW:0] r;
    if (l > LEN_MAX) begin
      r = LEN_MAX;
    end else begin
      r = l;
    end
    return r;
  endfunction

  state_t        state_r, state_nxt_s;
  logic [AW-1:0] idx_r, idx_nxt_s;
  logic [AW-1:0] src_r, src_nxt_s;
  logic [AW-1:0] dst_r, dst_nxt_s;
  logic [AW:0]   len_r, len_nxt_s;
  logic          mode_r, mode_nxt_s;
  logic [AW:0]   len_clamped_s;
  logic          accept_s;
  logic          last_s;
  logic          rd_next_s;
  logic          issue_s;
  logic          cmp_pend_r;
  logic [AW-1:0] cmp_idx_r;
  logic          cmp_hit_s;

  assign len_clamped_s = clamp_len(len);
  assign last_s        = ({1'b0, idx_r} == (len_r - LEN_ONE));
  // A read is issued in every RUN cycle; its data is consumed one cycle later.
  assign issue_s       = (state_r == ST_RUN);
  assign rd_next_s     = (state_nxt_s == ST_RUN);
  assign cmp_hit_s     = cmp_pend_r && (mem_q1 != mem_q2);
  // Write data comes straight from the registered read port, so the word read
  // in the previous cycle is written back without an extra pipeline stage.
  assign mem_din0      = mem_q1;

  // Next-state and command-latch selection.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    src_nxt_s   = src_r;
    dst_nxt_s   = dst_r;
    len_nxt_s   = len_r;
    mode_nxt_s  = mode_r;
    accept_s    = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          accept_s   = 1'b1;
          src_nxt_s  = src_base;
          dst_nxt_s  = dst_base;
          len_nxt_s  = len_clamped_s;
          mode_nxt_s = mode;
          idx_nxt_s  = '0;
          if (len_clamped_s != '0) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_DRAIN;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          idx_nxt_s = idx_r + AW'(1);
        end
      end
      ST_DRAIN: begin
        state_nxt_s = ST_DONE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, command registers and registered memory-port / status outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      idx_r      <= '0;
      src_r      <= '0;
      dst_r      <= '0;
      len_r      <= '0;
      mode_r     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mem_raddr1 <= '0;
      mem_raddr2 <= '0;
      mem_waddr0 <= '0;
      mem_we0    <= 1'b0;
      cmp_pend_r <= 1'b0;
      cmp_idx_r  <= '0;
    end else begin
      state_r    <= state_nxt_s;
      idx_r      <= idx_nxt_s;
      src_r      <= src_nxt_s;
      dst_r      <= dst_nxt_s;
      len_r      <= len_nxt_s;
      mode_r     <= mode_nxt_s;
      busy       <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DRAIN);
      done       <= (state_nxt_s == ST_DONE);
      mem_raddr1 <= rd_next_s ? (src_nxt_s + idx_nxt_s) : '0;
      mem_raddr2 <= (rd_next_s && mode_nxt_s) ? (dst_nxt_s + idx_nxt_s) : '0;
      mem_we0    <= issue_s && !mode_r;
      mem_waddr0 <= (issue_s && !mode_r) ? (dst_r + idx_r) : '0;
      cmp_pend_r <= issue_s && mode_r;
      cmp_idx_r  <= idx_r;
    end
  end

  // Mismatch bookkeeping: cleared on each accepted command, updated per compare.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mis_cnt   <= '0;
      mis_valid <= 1'b0;
      mis_idx   <= '0;
    end else if (accept_s) begin
      mis_cnt   <= '0;
      mis_valid <= 1'b0;
      mis_idx   <= '0;
    end else if (cmp_hit_s) begin
      mis_cnt <= mis_cnt + (AW+1)'(1);
      if (!mis_valid) begin
        mis_valid <= 1'b1;
        mis_idx   <= cmp_idx_r;
      end else begin
        mis_idx   <= mis_idx;
      end
    end else begin
      mis_cnt   <= mis_cnt;
      mis_valid <= mis_valid;
      mis_idx   <= mis_idx;
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: a cycle-level memory model serves
// the DUT's ports, and a word-level reference model predicts memory contents,
// mismatch results and per-cycle port activity for directed and random commands.
module tb_mem_copy_engine;
  localparam int AW = 2;
  localparam int DW = 17;
  localparam int N  = 4;
  localparam int LW = AW + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          mode;
  logic [AW-1:0] src_base;
  logic [AW-1:0] dst_base;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic [AW:0]   mis_cnt;
  logic          mis_valid;
  logic [AW-1:0] mis_idx;
  logic [AW-1:0] mem_raddr1;
  logic [DW-1:0] mem_q1;
  logic [AW-1:0] mem_raddr2;
  logic [DW-1:0] mem_q2;
  logic [AW-1:0] mem_waddr0;
  logic          mem_we0;
  logic [DW-1:0] mem_din0;

  always #5 clk = ~clk;

  mem_copy_engine #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .src_base(src_base), .dst_base(dst_base), .len(len),
    .busy(busy), .done(done), .mis_cnt(mis_cnt), .mis_valid(mis_valid),
    .mis_idx(mis_idx), .mem_raddr1(mem_raddr1), .mem_q1(mem_q1),
    .mem_raddr2(mem_raddr2), .mem_q2(mem_q2), .mem_waddr0(mem_waddr0),
    .mem_we0(mem_we0), .mem_din0(mem_din0)
  );

  // Memory under the DUT, plus a bench-side preload port used only while idle.
  logic [DW-1:0] mem [N];
  logic          pl_we;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  always @(posedge clk) begin
    mem_q1 <= mem[mem_raddr1];
    mem_q2 <= mem[mem_raddr2];
    if (mem_we0) mem[mem_waddr0] <= mem_din0;
    else if (pl_we) mem[pl_addr] <= pl_data;
  end

  logic [DW-1:0] ref_mem [N];
  int exp_cnt, exp_valid, exp_idx;
  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic preload(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                         input logic [DW-1:0] w2, input logic [DW-1:0] w3);
    logic [DW-1:0] v [N];
    v[0] = w0; v[1] = w1; v[2] = w2; v[3] = w3;
    for (int a = 0; a < N; a++) begin
      pl_we = 1'b1; pl_addr = AW'(a); pl_data = v[a]; ref_mem[a] = v[a];
      @(posedge clk); #1;
    end
    pl_we = 1'b0;
  endtask

  // Copy of nw words: read i sees memory before write i-1 lands at the same edge.
  task automatic ref_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int nw);
    logic [DW-1:0] v [N];
    for (int i = 0; i < nw; i++) begin
      v[i] = ref_mem[(int'(s) + i) % N];
      if (i > 0) ref_mem[(int'(d) + i - 1) % N] = v[i-1];
    end
    if (nw > 0) ref_mem[(int'(d) + nw - 1) % N] = v[nw-1];
  endtask

  task automatic check_mem(input string tag);
    for (int a = 0; a < N; a++) check_eq(tag, 32'(mem[a]), 32'(ref_mem[a]));
  endtask

  task automatic check_mis();
    check_eq("mis_cnt", 32'(mis_cnt), 32'(exp_cnt));
    check_eq("mis_valid", 32'(mis_valid), 32'(exp_valid));
    check_eq("mis_idx", 32'(mis_idx), 32'(exp_idx));
  endtask

  task automatic check_idle();
    check_eq("idle_busy", 32'(busy), 32'(0));
    check_eq("idle_done", 32'(done), 32'(0));
    check_eq("idle_we0", 32'(mem_we0), 32'(0));
    check_eq("idle_raddr1", 32'(mem_raddr1), 32'(0));
    check_mis();
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      check_idle();
    end
  endtask

  // Issues one command and checks every cycle through the done pulse. With
  // chain=1 the caller issues the next command in the done cycle.
  task automatic run_cmd(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input logic [AW:0] l, input bit chain);
    int L;
    L = (int'(l) > N) ? N : int'(l);
    exp_cnt = 0; exp_valid = 0; exp_idx = 0;
    if (m) begin
      for (int i = 0; i < L; i++) begin
        if (ref_mem[(int'(s) + i) % N] != ref_mem[(int'(d) + i) % N]) begin
          if (exp_valid == 0) exp_idx = i;
          exp_valid = 1;
          exp_cnt++;
        end
      end
    end else begin
      ref_copy(s, d, L);
    end
    start = 1'b1; mode = m; src_base = s; dst_base = d; len = l;
    for (int k = 0; k <= L + 1; k++) begin
      @(posedge clk); #1;
      check_eq("busy", 32'(busy), 32'(k <= L));
      check_eq("done", 32'(done), 32'(k == L + 1));
      check_eq("we0", 32'(mem_we0), 32'(!m && k >= 1 && k <= L));
      if (!m && k >= 1 && k <= L)
        check_eq("waddr0", 32'(mem_waddr0), 32'((int'(d) + k - 1) % N));
      if (k < L) begin
        check_eq("raddr1", 32'(mem_raddr1), 32'((int'(s) + k) % N));
        check_eq("raddr2", 32'(mem_raddr2), m ? 32'((int'(d) + k) % N) : 32'(0));
      end
      if (k <= L) begin
        // Start pulses with junk fields while busy must be ignored.
        start = 1'($urandom_range(0, 1)); mode = 1'($urandom);
        src_base = AW'($urandom); dst_base = AW'($urandom); len = LW'($urandom);
      end else if (!chain) begin
        start = 1'b0;
      end
    end
    check_mem("mem");
    check_mis();
  endtask

  function automatic logic [DW-1:0] rand_word();
    if ($urandom_range(0, 1) == 1) return DW'($urandom_range(0, 2));
    else return DW'($urandom);
  endfunction

  localparam logic [DW-1:0] WA = 17'h0A0A1;
  localparam logic [DW-1:0] WB = 17'h1B0B2;
  localparam logic [DW-1:0] WC = 17'h0C0C3;
  localparam logic [DW-1:0] WD = 17'h1D0D4;

  initial begin
    logic          rm;
    logic [AW-1:0] rs, rd;
    logic [AW:0]   rl;
    bit            ch, prev_ch;

    reset_n = 1'b0; start = 1'b0; mode = 1'b0; src_base = '0; dst_base = '0; len = '0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    exp_cnt = 0; exp_valid = 0; exp_idx = 0;
    repeat (2) @(posedge clk);
    #1;
    check_idle();
    reset_n = 1'b1;

    // Plain copy, wrap copy, overlapping copy.
    preload(WA, WB, WC, WD); run_cmd(1'b0, 2'd0, 2'd2, 3'd2, 1'b0); idle_cycles(2);
    check_eq("copy_word2", 32'(mem[2]), 32'(WA));
    preload(WA, WB, WC, WD); run_cmd(1'b0, 2'd3, 2'd1, 3'd2, 1'b0); idle_cycles(1);
    check_eq("wrap_word1", 32'(mem[1]), 32'(WD));
    preload(WA, WB, WC, WD); run_cmd(1'b0, 2'd0, 2'd1, 3'd3, 1'b0); idle_cycles(1);
    check_eq("ovl_word3", 32'(mem[3]), 32'(WC));

    // Compare with mismatches, reset clears results, then a matching compare.
    preload(17'd5, 17'd5, 17'd7, 17'd9); run_cmd(1'b1, 2'd0, 2'd2, 3'd2, 1'b0); idle_cycles(2);
    check_eq("cmp_cnt2", 32'(mis_cnt), 32'(2));
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_cnt = 0; exp_valid = 0; exp_idx = 0;
    check_idle();
    run_cmd(1'b1, 2'd0, 2'd2, 3'd2, 1'b0); idle_cycles(1);
    run_cmd(1'b1, 2'd0, 2'd1, 3'd1, 1'b0); idle_cycles(1);

    // Zero length, clamped length, then a back-to-back pair.
    run_cmd(1'b0, 2'd1, 2'd2, 3'd0, 1'b0); idle_cycles(1);
    preload(WA, WB, WC, WD); run_cmd(1'b0, 2'd1, 2'd3, 3'd7, 1'b1);
    run_cmd(1'b1, 2'd0, 2'd2, 3'd4, 1'b0); idle_cycles(1);

    // Reset during cycle 2 of a len=4 copy: writes 0 and 1 land, nothing more.
    preload(WA, WB, WC, WD);
    start = 1'b1; mode = 1'b0; src_base = 2'd0; dst_base = 2'd2; len = 3'd4;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("rst_busy0", 32'(busy), 32'(1));
    @(posedge clk); #1;
    start = 1'b1; len = 3'd0;
    @(posedge clk); #1;
    start = 1'b0; reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    ref_copy(2'd0, 2'd2, 2);
    exp_cnt = 0; exp_valid = 0; exp_idx = 0;
    check_idle();
    idle_cycles(3);
    check_mem("rst_mem");

    // Random commands, optionally chained back-to-back.
    prev_ch = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (!prev_ch && $urandom_range(0, 2) == 0) preload(rand_word(), rand_word(), rand_word(), rand_word());
      rm = 1'($urandom); rs = AW'($urandom); rd = AW'($urandom); rl = LW'($urandom_range(0, 7));
      ch = (t < 39) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_cmd(rm, rs, rd, rl, ch);
      if (!ch) idle_cycles($urandom_range(1, 2));
      prev_ch = ch;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
